// File: rtl/spe_param_accum_pkg.sv
// -----------------------------------------------------------------------------
// spe_pkg
// Shared definitions for the spiking-PE partial-sum accumulator and the
// packetizer blocks that talk to it.
//   spe_state_e : accumulator control FSM states
//   OMEM_ID     : node id of the output-memory path that serves potential
//                 requests
//   OP_*        : packet opcodes shared with the packetizers
//   acc_width() : width of a channel sum that cannot overflow
// -----------------------------------------------------------------------------
package spe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RES,
        ST_UPDATE,
        ST_SEND
    } spe_state_e;

    localparam logic [3:0] OMEM_ID      = 4'd12;

    localparam logic [3:0] OP_PSUM      = 4'h1;
    localparam logic [3:0] OP_POT_REQ   = 4'h2;
    localparam logic [3:0] OP_POT_RES   = 4'h3;
    localparam logic [3:0] OP_SPIKE_OUT = 4'h4;

    // Adding num_ch values of sum_w bits needs $clog2(num_ch) extra bits.
    function automatic int acc_width(input int sum_w, input int num_ch);
        return sum_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/spe_param_accum_if.sv
// -----------------------------------------------------------------------------
// spe_param_accum_if
// Handshake bundle of the partial-sum accumulator.
//   ps_valid/ps_ready, ps_ch, ps_data : partial-sum input stream
//   ts_done                           : first-timestep-complete pulse
//   req_valid/req_ready, req_id       : previous-potential request
//   res_valid/res_ready, res_data     : residual potential return
//   out_valid/out_ready, out_potential, out_spike, out_id : result stream
// Modports: master = surrounding fabric, slave = accumulator.
// -----------------------------------------------------------------------------
interface spe_param_accum_if #(
    parameter int NUM_CH    = 5,
    parameter int SUM_WIDTH = 13
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 ps_valid;
    logic                 ps_ready;
    logic [CH_W-1:0]      ps_ch;
    logic [SUM_WIDTH-1:0] ps_data;
    logic                 ts_done;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_id;
    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_WIDTH-1:0] res_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_WIDTH-1:0] out_potential;
    logic                 out_spike;
    logic [2:0]           out_id;

    modport master (
        output ps_valid, ps_ch, ps_data, ts_done, req_ready, res_valid, res_data, out_ready,
        input  ps_ready, req_valid, req_id, res_ready, out_valid, out_potential, out_spike, out_id
    );

    modport slave (
        input  ps_valid, ps_ch, ps_data, ts_done, req_ready, res_valid, res_data, out_ready,
        output ps_ready, req_valid, req_id, res_ready, out_valid, out_potential, out_spike, out_id
    );

endinterface

// File: rtl/spe_param_accum_chan_fifo.sv
// -----------------------------------------------------------------------------
// spe_chan_fifo
// Single-clock FIFO holding the partial sums of one source channel. DEPTH
// need not be a power of two; pointers wrap explicitly.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   dout       : head entry (valid while !empty)
//   full/empty : occupancy flags from registered state
// -----------------------------------------------------------------------------
module spe_chan_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: an entry is only observable after a push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spe_param_accum.sv
// -----------------------------------------------------------------------------
// spe_param_accum
// Spiking-PE membrane-potential accumulator. Collects one partial sum from
// each of NUM_CH channels, adds them, adds the previous potential (fetched
// from the output memory after the first timestep), thresholds, and emits the
// residual potential plus a spike flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spe_param_accum_if.slave (partial-sum input, ts_done, potential
//           request/return, result output)
// Build option: define SPE_LEAK_EN to subtract LEAK from the updated potential
// (floored at zero) before the threshold compare.
// -----------------------------------------------------------------------------
module spe_param_accum
    import spe_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int FIFO_DEPTH = 6,
    parameter int SUM_WIDTH  = 13,
    parameter int THRESHOLD  = 64,
    parameter int PE_ID      = 0,
    parameter int LEAK       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    spe_param_accum_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = acc_width(SUM_WIDTH, NUM_CH);
    localparam int P_W   = ACC_W + 1;
    localparam logic [SUM_WIDTH-1:0] THR_V   = SUM_WIDTH'(THRESHOLD);
    localparam logic [P_W-1:0]       POT_MAX = P_W'({SUM_WIDTH{1'b1}});

    spe_state_e           state_q;
    spe_state_e           state_d;
    logic [1:0]           ts_q;
    logic                 ts_pend_q;
    logic                 ts2_now;

    logic [NUM_CH-1:0]    push;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    empty;
    logic [SUM_WIDTH-1:0] fifo_dout [NUM_CH];
    logic                 ps_ready;
    logic                 all_ready;
    logic                 pop_all;

    logic [ACC_W-1:0]     sum_d;
    logic [ACC_W-1:0]     sum_p1;
    logic [SUM_WIDTH-1:0] prev_p1;
    logic [P_W-1:0]       pot_raw;
    logic [P_W-1:0]       pot_leak;
    logic [SUM_WIDTH-1:0] pot_sat;
    logic [SUM_WIDTH-1:0] pot_d;
    logic                 spike_d;
    logic [SUM_WIDTH-1:0] out_pot_q;
    logic                 out_spike_q;

    function automatic logic [SUM_WIDTH-1:0] sat_pot(input logic [P_W-1:0] v);
        if (v > POT_MAX) begin
            return {SUM_WIDTH{1'b1}};
        end
        return v[SUM_WIDTH-1:0];
    endfunction

`ifdef SPE_LEAK_EN
    function automatic logic [P_W-1:0] apply_leak(input logic [P_W-1:0] v);
        if (v > P_W'(LEAK)) begin
            return v - P_W'(LEAK);
        end
        return '0;
    endfunction
`else
    function automatic logic [P_W-1:0] apply_leak(input logic [P_W-1:0] v);
        return v;
    endfunction

    logic unused_leak;
    assign unused_leak = ^LEAK;
`endif

    // ---- Input stage: channel FIFOs -------------------------------------
    // Ready reflects the addressed FIFO's registered occupancy; an
    // out-of-range channel is always ready and its data is discarded.
    always_comb begin
        push     = '0;
        ps_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ps_ch == CH_W'(i)) begin
                ps_ready = !full[i];
                push[i]  = bus.ps_valid && !full[i];
            end
        end
    end

    assign bus.ps_ready = ps_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spe_chan_fifo #(
            .WIDTH (SUM_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   (bus.ps_data),
            .pop   (pop_all),
            .dout  (fifo_dout[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign all_ready = &(~empty);

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_d = sum_d + ACC_W'(fifo_dout[i]);
        end
    end

    // A timestep-done pulse seen now, or one held pending from a busy
    // period, takes effect before the pop decision in IDLE.
    assign ts2_now = (ts_q == 2'd2) || ts_pend_q || bus.ts_done;

    always_comb begin
        state_d = state_q;
        pop_all = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (all_ready) begin
                    pop_all = 1'b1;
                    state_d = ts2_now ? ST_REQ : ST_UPDATE;
                end
            end
            ST_REQ: begin
                if (bus.req_ready) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (bus.res_valid) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- Stage p1: registered channel sum and previous potential --------
    always_ff @(posedge clk) begin
        if (pop_all) begin
            sum_p1 <= sum_d;
        end
        if (state_q == ST_WAIT_RES && bus.res_valid) begin
            prev_p1 <= bus.res_data;
        end
    end

    // ts_q only changes in IDLE, so it still describes the in-flight set
    // when UPDATE decides whether to add the previous potential.
    always_comb begin
        pot_raw  = P_W'(sum_p1) + ((ts_q == 2'd2) ? P_W'(prev_p1) : '0);
        pot_leak = apply_leak(pot_raw);
        pot_sat  = sat_pot(pot_leak);
        if (pot_sat > THR_V) begin
            pot_d   = pot_sat - THR_V;
            spike_d = 1'b1;
        end else begin
            pot_d   = pot_sat;
            spike_d = 1'b0;
        end
    end

    // ---- Stage p2: control state and registered result ------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ts_q        <= 2'd1;
            ts_pend_q   <= 1'b0;
            out_pot_q   <= '0;
            out_spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (ts2_now) begin
                    ts_q      <= 2'd2;
                    ts_pend_q <= 1'b0;
                end
            end else if (bus.ts_done) begin
                ts_pend_q <= 1'b1;
            end
            if (state_q == ST_UPDATE) begin
                out_pot_q   <= pot_d;
                out_spike_q <= spike_d;
            end
        end
    end

    assign bus.req_valid     = (state_q == ST_REQ);
    assign bus.req_id        = 3'(PE_ID);
    assign bus.res_ready     = (state_q == ST_WAIT_RES);
    assign bus.out_valid     = (state_q == ST_SEND);
    assign bus.out_potential = out_pot_q;
    assign bus.out_spike     = out_spike_q;
    assign bus.out_id        = 3'(PE_ID);

endmodule

// File: tb/tb_spe_param_accum.sv
// -----------------------------------------------------------------------------
// tb_spe_param_accum
// Directed bench for spe_param_accum: a scoreboard queue is filled with the
// expected result whenever a channel set is driven, and a monitor pops and
// compares it whenever a result is handed over.
// Build option: SPE_LEAK_EN changes the expected potentials.
// -----------------------------------------------------------------------------
module tb_spe_param_accum;
    import spe_pkg::*;

    localparam int NUM_CH     = 5;
    localparam int FIFO_DEPTH = 6;
    localparam int SUM_WIDTH  = 13;
    localparam int THRESHOLD  = 64;
    localparam int PE_ID      = 0;
    localparam int LEAK       = 1;
    localparam int CH_W       = $clog2(NUM_CH);

    typedef struct packed {
        logic [SUM_WIDTH-1:0] pot;
        logic                 spike;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    exp_t stall_e;
    int   req_cnt  = 0;
    int   exp_req  = 0;
    bit   ts2      = 1'b0;
    int   res_val  = 30;

    spe_param_accum_if #(.NUM_CH(NUM_CH), .SUM_WIDTH(SUM_WIDTH)) bus ();

    spe_param_accum #(
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SUM_WIDTH  (SUM_WIDTH),
        .THRESHOLD  (THRESHOLD),
        .PE_ID      (PE_ID),
        .LEAK       (LEAK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input int prev, input int sum, input bit use_prev);
        int   p;
        exp_t e;
        p = sum + (use_prev ? prev : 0);
`ifdef SPE_LEAK_EN
        p = (p > LEAK) ? p - LEAK : 0;
`endif
        if (p > (1 << SUM_WIDTH) - 1) p = (1 << SUM_WIDTH) - 1;
        if (p > THRESHOLD) begin
            e.pot   = SUM_WIDTH'(p - THRESHOLD);
            e.spike = 1'b1;
        end else begin
            e.pot   = SUM_WIDTH'(p);
            e.spike = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input int sum);
        sb_q.push_back(model(res_val, sum, ts2));
        if (ts2) exp_req++;
    endtask

    task automatic push(input int ch, input int d);
        int n = 0;
        @(negedge clk);
        bus.ps_valid = 1'b1;
        bus.ps_ch    = CH_W'(ch);
        bus.ps_data  = SUM_WIDTH'(d);
        #1;
        while (bus.ps_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_ready", 32'(bus.ps_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.ps_valid = 1'b0;
    endtask

    task automatic push_set(input int a, input int b, input int c, input int d, input int e);
        push_exp(a + b + c + d + e);
        push(0, a);
        push(1, b);
        push(2, c);
        push(3, d);
        push(4, e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_res_ready(input string tag);
        int n = 0;
        while (bus.res_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.res_ready), 32'd1);
    endtask

    // Monitor: counts potential requests and scores every handed-over result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
                req_cnt++;
                chk("req_id", 32'(bus.req_id), 32'(PE_ID));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_output observed pot=%0d spike=%0d expected=no output",
                           bus.out_potential, bus.out_spike);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_potential", 32'(bus.out_potential), 32'(mon_e.pot));
                    chk("out_spike", 32'(bus.out_spike), 32'(mon_e.spike));
                    chk("out_id", 32'(bus.out_id), 32'(PE_ID));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps_valid  = 1'b0;
        bus.ps_ch     = '0;
        bus.ps_data   = '0;
        bus.ts_done   = 1'b0;
        bus.req_ready = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = SUM_WIDTH'(res_val);
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        $display("TB_INFO omem_id=%0d opcodes=%0h %0h %0h %0h",
                 OMEM_ID, OP_PSUM, OP_POT_REQ, OP_POT_RES, OP_SPIKE_OUT);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ps_ready", 32'(bus.ps_ready), 32'd1);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_potential", 32'(bus.out_potential), 32'd0);
        chk("rst_out_spike", 32'(bus.out_spike), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First timestep, below threshold, with latency check
        push_set(10, 20, 5, 3, 2);
        chk("lat_before_pop", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_after_pop", 32'(bus.out_valid), 32'd0);
        chk("ts1_no_req", 32'(bus.req_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_after_update", 32'(bus.out_valid), 32'd1);
        drain("drain_ts1_a");

        // First timestep, above threshold
        push_set(30, 20, 10, 5, 4);
        drain("drain_ts1_b");
        chk("ts1_req_count", 32'(req_cnt), 32'(exp_req));

        // Second timestep: previous potential fetched
        @(negedge clk);
        bus.ts_done = 1'b1;
        @(posedge clk);
        #1;
        bus.ts_done = 1'b0;
        ts2 = 1'b1;
        push_set(10, 10, 10, 10, 10);
        drain("drain_ts2");
        chk("ts2_req_count", 32'(req_cnt), 32'(exp_req));

        // Fill ch0 alone, then feed the other channels
        for (int k = 1; k <= FIFO_DEPTH; k++) push(0, k);
        @(negedge clk);
        bus.ps_ch = CH_W'(0);
        #1;
        chk("ch0_full_ready", 32'(bus.ps_ready), 32'd0);
        bus.ps_ch = CH_W'(1);
        #1;
        chk("ch1_empty_ready", 32'(bus.ps_ready), 32'd1);
        bus.ps_ch = CH_W'(5);
        #1;
        chk("bad_ch_ready", 32'(bus.ps_ready), 32'd1);
        push(5, 500);
        push(7, 500);
        for (int k = 1; k <= FIFO_DEPTH; k++) begin
            push_exp(k + 8);
            for (int c = 1; c < NUM_CH; c++) push(c, 2);
        end
        drain("drain_fill");
        chk("fill_req_count", 32'(req_cnt), 32'(exp_req));

        // Output back-pressure while the FIFOs keep accepting
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        stall_e = model(res_val, 100, ts2);
        push_set(20, 20, 20, 20, 20);
        wait_out_valid("stall_out_valid_rise");
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push(0, 3);
            @(negedge clk);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out_potential", 32'(bus.out_potential), 32'(stall_e.pot));
            chk("stall_out_spike", 32'(bus.out_spike), 32'(stall_e.spike));
        end
        @(negedge clk);
        bus.ps_ch = CH_W'(0);
        #1;
        chk("ch0_full_in_send", 32'(bus.ps_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            push_exp(3 + 4);
            for (int c = 1; c < NUM_CH; c++) push(c, 1);
        end
        drain("drain_stall");
        chk("stall_req_count", 32'(req_cnt), 32'(exp_req));

        // Reset while waiting for the residual potential
        @(negedge clk);
        bus.res_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) push(c, 7);
        exp_req++;
        wait_res_ready("reset_wait_res");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("midrst_res_ready", 32'(bus.res_ready), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_potential", 32'(bus.out_potential), 32'd0);
        chk("midrst_out_spike", 32'(bus.out_spike), 32'd0);
        chk("midrst_ps_ready", 32'(bus.ps_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_valid = 1'b1;
        ts2 = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_output_after_reset", 32'(bus.out_valid), 32'd0);
        push_set(1, 2, 3, 4, 5);
        drain("drain_after_reset");
        chk("after_reset_req_count", 32'(req_cnt), 32'(exp_req));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
